cpu_5_oci_dct_packer: RTL and testbench
=======================================

# cpu_5_oci_dct_packer

Transmit-side counterpart of the OCI debug compressed-trace (DCT) sink. It packs 2-bit trace atoms from the CPU trace logic into a 30-bit `dct_buffer` with a 4-bit `dct_count`. Each completed or flushed frame is presented as one 34-bit word on a valid/ready handshake toward the trace FIFO. The producer cannot be stalled, so a frame that cannot be handed off is dropped and counted.

## Interface
Parameters:
- `ATOMS`, default 15: atoms per full frame. Legal range 1..15. Buffer width is fixed at 30 bits.
- `LOST_W`, default 8: width of the saturating lost-frame counter.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-high reset.
- `atom_valid`  in  1: atom present this cycle; always accepted.
- `atom`  in  2: trace atom code.
- `flush`  in  1: emit the partial frame now.
- `out_ready`  in  1: downstream accepts `out_word`.
- `out_valid`  out  1: `out_word` holds an unaccepted frame.
- `out_word`  out  34: frame word, `{dct_count[3:0], dct_buffer[29:0]}`.
- `dct_buffer`  out  30: live accumulator contents.
- `dct_count`  out  4: live accumulator atom count.
- `overflow`  out  1: sticky flag, set when any frame has been dropped.
- `overflow_clr`  in  1: clears `overflow` and `lost_frames`.
- `lost_frames`  out  `LOST_W`: saturating count of dropped frames.

## Operation
- Accumulate on `atom_valid`: `buf_n = {dct_buffer[27:0], atom}` and `cnt_n = dct_count + 1`. The newest atom always sits in bits [1:0]. Bits above `2*cnt_n` are zero.
- Frame completion occurs when `cnt_n == ATOMS`.
- Flush request occurs when `flush` is high and `cnt_n != 0`. `cnt_n` already includes any atom accepted in the same cycle. A flush with `cnt_n == 0` is a no-op.
- Emit is true when completion or flush request is true. Completion and flush in the same cycle produce exactly one frame.
- The slot is free when `!out_valid || out_ready`.
- Emit with the slot free:
  - `out_word <= {cnt_n, buf_n}` and `out_valid <= 1`.
  - The accumulator clears to count 0 and buffer 0.
- Emit with the slot busy:
  - The frame is dropped and the accumulator clears.
  - `overflow <= 1`.
  - `lost_frames` increments and saturates at all-ones.
  - `out_word` is unchanged.
- No emit: the accumulator takes `buf_n`/`cnt_n`. Without `atom_valid` it holds.
- When `out_valid && out_ready` and there is no new emit, `out_valid <= 0`.
- `out_word` is stable while `out_valid && !out_ready`.
- `overflow_clr` clears `overflow` and `lost_frames`. If a drop happens in the same cycle, the drop wins: `overflow = 1` and `lost_frames = 1`.
- State: accumulator (buffer plus count) and a one-entry output slot. There is no further FSM.

## Timing
- Reset values: `out_valid` 0, `out_word` 0, `dct_buffer` 0, `dct_count` 0, `overflow` 0, `lost_frames` 0.
- Reset mid-frame discards the accumulator and any pending output word.
- Latency: a frame appears on `out_valid` in the cycle after the completing atom or flush.
- Back-to-back frames are allowed. The slot reloads in the same cycle it is accepted, so one frame per cycle is sustainable.
- Live `dct_buffer`/`dct_count` update the cycle after the atom. They read 0 the cycle after an emit.
- `dct_count` never exceeds `ATOMS` and never holds the value `ATOMS` after a clock edge.

## Test plan
- Full frame: with `out_ready`=1, send 15 atoms `2'b01` -> one cycle later `out_valid`=1 and `out_word`=`{4'hF, 30'h15555555}`. `dct_count` is then 0.
- Partial flush: send atoms 3, 2, 1, then pulse `flush` alone -> `out_word`=`{4'd3, 30'h00000039}`. A second `flush` produces nothing.
- Flush with atom in the same cycle: 2 atoms `2'b11` followed by a cycle with atom `2'b10` plus `flush` -> `out_word`=`{4'd3, 30'h0000003E}`.
- Backpressure drop: hold `out_ready`=0 and send 30 atoms -> the first frame is held unchanged, the second is dropped, and `overflow`=1 with `lost_frames`=1. Then assert `out_ready` -> the first frame is accepted and `out_valid` falls.
- Saturation and clear: with `LOST_W`=2, cause 5 drops -> `lost_frames`=3. Pulse `overflow_clr` -> 0/0. Repeat with a drop in the same cycle -> `overflow`=1, `lost_frames`=1.
- Reset mid-frame: after 7 atoms with `out_valid`=1, assert `reset` asynchronously -> all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_5_oci_dct_packer.sv
// OCI compressed-trace packer: shifts 2-bit trace atoms into a 30-bit frame and
// hands completed or flushed frames to a one-entry valid/ready slot, dropping on overflow.
module cpu_5_oci_dct_packer #(
    parameter int ATOMS  = 15,
    parameter int LOST_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              atom_valid,
    input  logic [1:0]        atom,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [33:0]       out_word,
    output logic [29:0]       dct_buffer,
    output logic [3:0]        dct_count,
    output logic              overflow,
    input  logic              overflow_clr,
    output logic [LOST_W-1:0] lost_frames
);

    logic [29:0]       buf_q, buf_d, buf_n;
    logic [3:0]        cnt_q, cnt_d, cnt_n;
    logic              out_valid_q, out_valid_d;
    logic [33:0]       out_word_q, out_word_d;
    logic              overflow_q, overflow_d;
    logic [LOST_W-1:0] lost_q, lost_d;
    logic              emit, slot_free, drop;

    // The producer never stalls, so an atom arriving with a flush belongs to the flushed frame.
    always_comb begin
        buf_n = atom_valid ? {buf_q[27:0], atom} : buf_q;
        cnt_n = atom_valid ? cnt_q + 4'd1 : cnt_q;
        emit      = (cnt_n == 4'(ATOMS)) || (flush && (cnt_n != 4'd0));
        slot_free = !out_valid_q || out_ready;
        drop      = emit && !slot_free;
    end

    // NOTE: every _d gets its hold value first so no path through the block infers a latch.
    always_comb begin
        buf_d       = buf_n;
        cnt_d       = cnt_n;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        overflow_d  = overflow_q;
        lost_d      = lost_q;

        if (emit) begin
            buf_d = '0;
            cnt_d = '0;
            if (slot_free) begin
                out_word_d  = {cnt_n, buf_n};
                out_valid_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A drop in the same cycle as a clear wins and restarts the count at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_clr)
                lost_d = LOST_W'(1);
            else if (lost_q != '1)
                lost_d = lost_q + 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
            lost_d     = '0;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            overflow_q  <= 1'b0;
            lost_q      <= '0;
        end else begin
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            overflow_q  <= overflow_d;
            lost_q      <= lost_d;
        end
    end

    assign dct_buffer  = buf_q;
    assign dct_count   = cnt_q;
    assign out_valid   = out_valid_q;
    assign out_word    = out_word_q;
    assign overflow    = overflow_q;
    assign lost_frames = lost_q;

endmodule

// File: tb/tb_cpu_5_oci_dct_packer.sv
// Self-checking bench for cpu_5_oci_dct_packer: directed vector table, hand sequences
// for frame, backpressure, saturation and async reset, then random traffic vs a queue model.
module tb_cpu_5_oci_dct_packer;

    localparam int ATOMS  = 15;
    localparam int LOST_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              atom_valid = 1'b0;
    logic [1:0]        atom = 2'd0;
    logic              flush = 1'b0;
    logic              out_ready = 1'b0;
    logic              overflow_clr = 1'b0;
    logic              out_valid;
    logic [33:0]       out_word;
    logic [29:0]       dct_buffer;
    logic [3:0]        dct_count;
    logic              overflow;
    logic [LOST_W-1:0] lost_frames;

    cpu_5_oci_dct_packer #(.ATOMS(ATOMS), .LOST_W(LOST_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .atom_valid   (atom_valid),
        .atom         (atom),
        .flush        (flush),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_word     (out_word),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .lost_frames  (lost_frames)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pending atoms kept as a list, frame value formed arithmetically.
    int          acc[$];
    logic        m_valid;
    logic [33:0] m_word;
    logic        m_ovf;
    int          m_lost;

    function automatic logic [29:0] pack_acc();
        longint v = 0;
        foreach (acc[i]) v = v * 4 + acc[i];
        return 30'(v);
    endfunction

    function automatic logic [79:0] model_obs();
        return {8'd0, m_valid, m_word, pack_acc(), 4'(acc.size()), m_ovf, 2'(m_lost)};
    endfunction

    function automatic logic [79:0] dut_obs();
        return {8'd0, out_valid, out_word, dct_buffer, dct_count, overflow, lost_frames};
    endfunction

    task automatic model_reset();
        acc.delete();
        m_valid = 1'b0;
        m_word  = '0;
        m_ovf   = 1'b0;
        m_lost  = 0;
    endtask

    task automatic model_step(input logic av, input logic [1:0] a, input logic fl,
                              input logic rdy, input logic clr);
        int   n;
        bit   do_emit, dropped;
        logic [33:0] frame;
        dropped = 0;
        if (av) acc.push_back(int'(a));
        n = acc.size();
        do_emit = (n == ATOMS) || (fl && n != 0);
        if (do_emit) begin
            frame = {4'(n), pack_acc()};
            acc.delete();
            if (!m_valid || rdy) begin
                m_word  = frame;
                m_valid = 1'b1;
            end else begin
                dropped = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (dropped) begin
            m_ovf  = 1'b1;
            m_lost = clr ? 1 : ((m_lost < 3) ? m_lost + 1 : 3);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_lost = 0;
        end
    endtask

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Applies one cycle of inputs, advances the model, and compares everything after the edge.
    task automatic step(input logic av, input logic [1:0] a, input logic fl,
                        input logic rdy, input logic clr, input string name);
        atom_valid   = av;
        atom         = a;
        flush        = fl;
        out_ready    = rdy;
        overflow_clr = clr;
        @(posedge clk);
        model_step(av, a, fl, rdy, clr);
        #1;
        check(name, dut_obs(), model_obs());
    endtask

    task automatic do_reset();
        atom_valid = 0; flush = 0; out_ready = 0; overflow_clr = 0; atom = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        av;
        logic [1:0]  a;
        logic        fl;
        logic        rdy;
        logic        exp_valid;
        logic [33:0] exp_word;
        logic [29:0] exp_buf;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1, 2'd3, 0, 1, 0, 34'h0,             30'h03, 4'd1};
        vecs[1] = '{1, 2'd2, 0, 1, 0, 34'h0,             30'h0E, 4'd2};
        vecs[2] = '{1, 2'd1, 0, 1, 0, 34'h0,             30'h39, 4'd3};
        vecs[3] = '{0, 2'd0, 1, 1, 1, {4'd3, 30'h39},   30'h00, 4'd0};
        vecs[4] = '{0, 2'd0, 1, 1, 0, {4'd3, 30'h39},   30'h00, 4'd0};
        vecs[5] = '{1, 2'd3, 0, 1, 0, {4'd3, 30'h39},   30'h03, 4'd1};
        vecs[6] = '{1, 2'd3, 0, 1, 0, {4'd3, 30'h39},   30'h0F, 4'd2};
        vecs[7] = '{1, 2'd2, 1, 1, 1, {4'd3, 30'h3E},   30'h00, 4'd0};
        vecs[8] = '{0, 2'd0, 0, 1, 0, {4'd3, 30'h3E},   30'h00, 4'd0};

        model_reset();
        #1;
        check("reset_state", dut_obs(), 80'd0);
        do_reset();
        check("after_reset_release", dut_obs(), 80'd0);

        // Partial flush, repeated flush no-op, flush with same-cycle atom.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].av, vecs[i].a, vecs[i].fl, vecs[i].rdy, 1'b0, $sformatf("vec%0d_model", i));
            check($sformatf("vec%0d", i), {46'd0, out_valid, out_word, dct_count},
                  {46'd0, vecs[i].exp_valid, vecs[i].exp_word, vecs[i].exp_cnt});
            check($sformatf("vec%0d_buf", i), {50'd0, dct_buffer}, {50'd0, vecs[i].exp_buf});
        end

        // Full 15-atom frame.
        do_reset();
        for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 1, 0, "full_frame_fill");
        check("full_frame_word", {45'd0, out_valid, out_word}, {45'd0, 1'b1, 4'hF, 30'h15555555});
        check("full_frame_cnt", {76'd0, dct_count}, 80'd0);
        step(0, 0, 0, 1, 0, "full_frame_accept");
        check("full_frame_drained", {79'd0, out_valid}, 80'd0);

        // Backpressure: first frame held, second dropped.
        do_reset();
        for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 0, 0, "bp_first");
        for (int i = 0; i < 15; i++) step(1, 2'b10, 0, 0, 0, "bp_second");
        check("bp_held_word", {45'd0, out_valid, out_word}, {45'd0, 1'b1, 4'hF, 30'h15555555});
        check("bp_overflow", {77'd0, overflow, lost_frames}, {77'd0, 1'b1, 2'd1});
        step(0, 0, 0, 1, 0, "bp_accept");
        check("bp_valid_falls", {79'd0, out_valid}, 80'd0);

        // Saturating lost counter, clear, and clear colliding with a drop.
        do_reset();
        step(1, 2'd2, 1, 0, 0, "sat_fill_slot");
        for (int i = 0; i < 5; i++) step(1, 2'd1, 1, 0, 0, "sat_drop");
        check("sat_lost", {77'd0, overflow, lost_frames}, {77'd0, 1'b1, 2'd3});
        step(0, 0, 0, 0, 1, "sat_clear");
        check("sat_cleared", {77'd0, overflow, lost_frames}, 80'd0);
        step(1, 2'd3, 1, 0, 1, "sat_clear_with_drop");
        check("sat_drop_wins", {77'd0, overflow, lost_frames}, {77'd0, 1'b1, 2'd1});

        // Asynchronous reset mid-frame while a word is pending.
        do_reset();
        step(1, 2'd1, 1, 0, 0, "rst_pending");
        for (int i = 0; i < 7; i++) step(1, 2'(i), 0, 0, 0, "rst_atoms");
        check("rst_precond", {75'd0, out_valid, dct_count}, {75'd0, 1'b1, 4'd7});
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset_clears", dut_obs(), 80'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 2'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
